// File: rtl/rr_tdm_mac.sv
// rr_tdm_mac: round-robin TDM multiplier.
// A work-conserving arbiter grants one valid channel per cycle. The granted sample is
// multiplied by that channel's free-running grant counter, and the product is delayed
// MULT_LAT cycles and emitted tagged with its channel index.
// Optional feature macro: RR_TDM_ACCUM_EN adds per-channel accumulation of the products,
// with the add folded into the final pipeline stage.
module rr_tdm_mac #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned CNT_MAX   = 2**CNT_W - 1,
    parameter int unsigned MULT_LAT  = 3,
    parameter int unsigned ACC_GUARD = 4,
`ifdef RR_TDM_ACCUM_EN
    localparam bit          ACC_EN   = 1'b1,
`else
    localparam bit          ACC_EN   = 1'b0,
`endif
    localparam int unsigned CH_W     = $clog2(NUM_CH),
    localparam int unsigned PROD_W   = DATA_W + CNT_W,
    localparam int unsigned OUT_W    = PROD_W + (ACC_EN ? ACC_GUARD : 0)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_ch,
    output logic [OUT_W-1:0]         out_data
);

    localparam int unsigned LAST = MULT_LAT - 1;

    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];

    logic              gnt_vld;
    logic [CH_W-1:0]   gnt_ch;
    logic [DATA_W-1:0] gnt_data;
    logic [CNT_W-1:0]  gnt_cnt;
    logic              gnt_wrap;
    logic [PROD_W-1:0] gnt_prod;

    // Stage inputs (index 0 is the fresh grant) and stage registers.
    logic              stg_v   [MULT_LAT];
    logic [CH_W-1:0]   stg_ch  [MULT_LAT];
    logic [OUT_W-1:0]  stg_dat [MULT_LAT];
    logic              pv_q    [MULT_LAT];
    logic [CH_W-1:0]   pch_q   [MULT_LAT];
    logic [OUT_W-1:0]  pd_q    [MULT_LAT];
    logic [OUT_W-1:0]  fin_dat;

`ifdef RR_TDM_ACCUM_EN
    logic              stg_w   [MULT_LAT];
    logic              pw_q    [MULT_LAT];
    logic [OUT_W-1:0]  acc_q   [NUM_CH];
    logic [OUT_W-1:0]  acc_sum;
`endif

    // Priority search starting at the pointer; nothing is granted while in reset.
    always_comb begin
        int unsigned     idx;
        logic [CH_W-1:0] k;
        idx     = 0;
        k       = '0;
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            k = CH_W'(idx);
            if (!gnt_vld && in_valid[k]) begin
                gnt_vld = 1'b1;
                gnt_ch  = k;
            end
        end
        gnt_vld = gnt_vld & ~rst;
    end

    // One-hot ready for the granted channel.
    always_comb begin
        in_ready = '0;
        if (gnt_vld) in_ready[gnt_ch] = 1'b1;
    end

    // Operand select, product and pointer next-state.
    always_comb begin
        gnt_data = '0;
        gnt_cnt  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (gnt_ch == CH_W'(k)) begin
                gnt_data = in_data[k*DATA_W +: DATA_W];
                gnt_cnt  = cnt_q[k];
            end
        end
        gnt_wrap = (gnt_cnt == CNT_W'(CNT_MAX));
        gnt_prod = PROD_W'(gnt_data) * PROD_W'(gnt_cnt);
        ptr_d    = ptr_q;
        if (gnt_vld) begin
            ptr_d = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
        end
    end

    // Arbiter pointer and per-channel grant counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (gnt_vld) cnt_q[gnt_ch] <= gnt_wrap ? '0 : gnt_cnt + CNT_W'(1);
        end
    end

    // Wire up stage inputs from the grant and the previous stage.
    always_comb begin
        stg_v[0]   = gnt_vld;
        stg_ch[0]  = gnt_ch;
        stg_dat[0] = OUT_W'(gnt_prod);
`ifdef RR_TDM_ACCUM_EN
        stg_w[0]   = gnt_wrap;
`endif
        for (int unsigned i = 1; i < MULT_LAT; i++) begin
            stg_v[i]   = pv_q[i-1];
            stg_ch[i]  = pch_q[i-1];
            stg_dat[i] = pd_q[i-1];
`ifdef RR_TDM_ACCUM_EN
            stg_w[i]   = pw_q[i-1];
`endif
        end
    end

    // Final-stage value: raw product, or the updated running sum.
    always_comb begin
`ifdef RR_TDM_ACCUM_EN
        acc_sum = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (stg_ch[LAST] == CH_W'(k)) acc_sum = acc_q[k] + stg_dat[LAST];
        end
        fin_dat = acc_sum;
`else
        fin_dat = stg_dat[LAST];
`endif
    end

    // Token pipeline; payload only loads with a valid token so the output stage holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MULT_LAT; i++) begin
                pv_q[i]  <= 1'b0;
                pch_q[i] <= '0;
                pd_q[i]  <= '0;
`ifdef RR_TDM_ACCUM_EN
                pw_q[i]  <= 1'b0;
`endif
            end
        end else begin
            for (int unsigned i = 0; i < MULT_LAT; i++) begin
                pv_q[i] <= stg_v[i];
                if (stg_v[i]) begin
                    pch_q[i] <= stg_ch[i];
                    pd_q[i]  <= (i == LAST) ? fin_dat : stg_dat[i];
`ifdef RR_TDM_ACCUM_EN
                    pw_q[i]  <= stg_w[i];
`endif
                end
            end
        end
    end

`ifdef RR_TDM_ACCUM_EN
    // Per-channel accumulators; a sum built from a terminal-count grant restarts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
        end else if (stg_v[LAST]) begin
            acc_q[stg_ch[LAST]] <= stg_w[LAST] ? '0 : acc_sum;
        end
    end
`endif

    assign out_valid = pv_q[LAST];
    assign out_ch    = pch_q[LAST];
    assign out_data  = pd_q[LAST];

endmodule
